// File: rtl/xava_data_responder_if.sv
// rtl/xava_data_responder_if.sv - OBI-style data port between vector LSU and memory responder
interface xava_data_responder_if;
   logic        data_req;
   logic        data_gnt;
   logic [31:0] data_addr;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_wdata;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        data_oob;

   modport master (
      output data_req, data_addr, data_we, data_be, data_wdata,
      input  data_gnt, data_rvalid, data_rdata, data_oob
   );

   modport slave (
      input  data_req, data_addr, data_we, data_be, data_wdata,
      output data_gnt, data_rvalid, data_rdata, data_oob
   );
endinterface

// File: rtl/xava_data_responder.sv
// rtl/xava_data_responder.sv - word SRAM responder with grant stalls, fixed latency and outstanding limit
module xava_data_responder #(
   parameter int unsigned MEM_WORDS_LOG2  = 14,
   parameter int unsigned RSP_LATENCY     = 2,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned STALL_CYCLES    = 0,
   parameter logic [31:0] BASE_ADDR       = 32'h0
) (
   input logic                  clk_i,
   input logic                  rst_i,
   xava_data_responder_if.slave bus_io
);
   localparam int unsigned MEM_WORDS = 1 << MEM_WORDS_LOG2;
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned SW = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

   logic [31:0]               mem_q [MEM_WORDS];
   logic [OW-1:0]             outst_q, outst_d;
   logic [SW-1:0]             stall_q, stall_d;
   logic [RSP_LATENCY-1:0]    pv_q, pv_d;
   logic [RSP_LATENCY-1:0]    po_q, po_d;
   logic [31:0]               pd_q [RSP_LATENCY];
   logic [31:0]               pd_d [RSP_LATENCY];

   logic [29:0]               word_off;
   logic [MEM_WORDS_LOG2-1:0] index;
   logic                      in_range;
   logic                      retire;
   logic                      gnt;
   logic                      accept;

   // BASE_ADDR is word aligned, so subtracting word numbers equals (addr-BASE)>>2
   assign word_off = bus_io.data_addr[31:2] - BASE_ADDR[31:2];
   assign index    = word_off[MEM_WORDS_LOG2-1:0];
   assign in_range = (bus_io.data_addr >= BASE_ADDR) && ((word_off >> MEM_WORDS_LOG2) == '0);

   // A response leaving the pipe frees its slot in the same cycle
   assign retire = pv_q[RSP_LATENCY-1];
   assign gnt    = !rst_i && (stall_q == '0) && ((outst_q < OW'(MAX_OUTSTANDING)) || retire);
   assign accept = bus_io.data_req && gnt;

   always_comb begin
      outst_d = outst_q;
      if (accept && !retire) begin
         outst_d = outst_q + 1'b1;
      end else if (!accept && retire) begin
         outst_d = outst_q - 1'b1;
      end

      stall_d = stall_q;
      if (accept) begin
         stall_d = SW'(STALL_CYCLES);
      end else if (stall_q != '0) begin
         stall_d = stall_q - 1'b1;
      end

      pv_d    = '0;
      po_d    = '0;
      pv_d[0] = accept;
      po_d[0] = accept && !in_range;
      pd_d[0] = (accept && in_range && !bus_io.data_we) ? mem_q[index] : '0;
      for (int i = 1; i < RSP_LATENCY; i++) begin
         pv_d[i] = pv_q[i-1];
         po_d[i] = po_q[i-1];
         pd_d[i] = pd_q[i-1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outst_q <= '0;
         stall_q <= '0;
         pv_q    <= '0;
         po_q    <= '0;
         for (int i = 0; i < RSP_LATENCY; i++) begin
            pd_q[i] <= '0;
         end
      end else begin
         outst_q <= outst_d;
         stall_q <= stall_d;
         pv_q    <= pv_d;
         po_q    <= po_d;
         for (int i = 0; i < RSP_LATENCY; i++) begin
            pd_q[i] <= pd_d[i];
         end
      end
   end

   // Memory contents survive reset; accept already excludes reset
   always_ff @(posedge clk_i) begin
      if (accept && in_range && bus_io.data_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus_io.data_be[b]) begin
               mem_q[index][8*b +: 8] <= bus_io.data_wdata[8*b +: 8];
            end
         end
      end
   end

   assign bus_io.data_gnt    = gnt;
   assign bus_io.data_rvalid = pv_q[RSP_LATENCY-1];
   assign bus_io.data_oob    = po_q[RSP_LATENCY-1];
   assign bus_io.data_rdata  = pd_q[RSP_LATENCY-1];
endmodule

// File: tb/tb_xava_data_responder.sv
// tb/tb_xava_data_responder.sv - scoreboard bench for xava_data_responder
module tb_xava_data_responder;
   localparam int unsigned LAT  = 2;
   localparam int unsigned MAXO = 2;
   localparam int unsigned LOG2 = 14;

   typedef struct {
      logic [31:0] rdata;
      logic        oob;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   b_rv = 0;
   int   b_acc = 0;
   int   c_acc = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic [31:0] model [int unsigned];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   xava_data_responder_if aif ();
   xava_data_responder_if bif ();
   xava_data_responder_if cif ();

   xava_data_responder u_a (.clk_i(clk), .rst_i(rst), .bus_io(aif));
   xava_data_responder #(.RSP_LATENCY(3), .MAX_OUTSTANDING(2)) u_b (.clk_i(clk), .rst_i(rst), .bus_io(bif));
   xava_data_responder #(.MEM_WORDS_LOG2(4), .STALL_CYCLES(2), .BASE_ADDR(32'h1000))
      u_c (.clk_i(clk), .rst_i(rst), .bus_io(cif));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every cycle out of reset either a due response or an idle bus
   always @(negedge clk) begin
      if (!rst) begin
         if (aif.data_rvalid) begin
            if (sb.size() == 0) begin
               check("extra_rvalid", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check("rdata", aif.data_rdata, mon_e.rdata);
               check("oob", {31'd0, aif.data_oob}, {31'd0, mon_e.oob});
               check("rsp_cycle", cyc, mon_e.due);
            end
         end else begin
            if (sb.size() != 0 && sb[0].due <= cyc) begin
               void'(sb.pop_front());
               check("missing_rvalid", 32'd0, 32'd1);
            end
            check("idle_rdata", aif.data_rdata, 32'd0);
            check("idle_oob", {31'd0, aif.data_oob}, 32'd0);
         end
      end
      if (bif.data_rvalid) b_rv++;
   end

   task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
      int unsigned idx;
      int          tries;
      exp_t        e;
      @(negedge clk);
      aif.data_req   = 1'b1;
      aif.data_we    = we;
      aif.data_addr  = addr;
      aif.data_be    = be;
      aif.data_wdata = wd;
      #1;
      tries = 0;
      forever begin
         check("gnt", {31'd0, aif.data_gnt}, {31'd0, (sb.size() < MAXO)});
         if (aif.data_gnt) break;
         tries++;
         if (tries > 16) begin
            check("gnt_timeout", 32'd0, 32'd1);
            return;
         end
         @(negedge clk);
         #1;
      end
      idx     = addr >> 2;
      e.oob   = !(idx < (1 << LOG2));
      e.due   = cyc + LAT;
      e.rdata = 32'h0;
      if (!e.oob && we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
         end
      end else if (!e.oob && !we) begin
         e.rdata = model.exists(idx) ? model[idx] : 32'h0;
      end
      sb.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      aif.data_req = 1'b0;
   endtask

   task automatic drain();
      idle();
      for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
      check("drain", sb.size(), 32'd0);
   endtask

   task automatic c_read(input logic [31:0] addr, input logic exp_oob);
      int k;
      @(negedge clk);
      cif.data_req  = 1'b1;
      cif.data_we   = 1'b0;
      cif.data_addr = addr;
      #1;
      for (k = 0; k < 8 && !cif.data_gnt; k++) begin
         @(negedge clk);
         #1;
      end
      @(negedge clk);
      cif.data_req = 1'b0;
      for (k = 0; k < 8 && !cif.data_rvalid; k++) @(negedge clk);
      check("c_rvalid", {31'd0, cif.data_rvalid}, 32'd1);
      check("c_oob", {31'd0, cif.data_oob}, {31'd0, exp_oob});
      if (exp_oob) check("c_oob_rdata", cif.data_rdata, 32'd0);
      @(negedge clk);
   endtask

   initial begin
      aif.data_req = 1'b0; aif.data_we = 1'b0; aif.data_addr = '0; aif.data_be = '0; aif.data_wdata = '0;
      bif.data_req = 1'b0; bif.data_we = 1'b0; bif.data_addr = '0; bif.data_be = '0; bif.data_wdata = '0;
      cif.data_req = 1'b0; cif.data_we = 1'b0; cif.data_addr = 32'h1000; cif.data_be = '0; cif.data_wdata = '0;

      #1;
      check("rst_gnt", {31'd0, aif.data_gnt}, 32'd0);
      check("rst_rvalid", {31'd0, aif.data_rvalid}, 32'd0);
      check("rst_rdata", aif.data_rdata, 32'd0);
      check("rst_oob", {31'd0, aif.data_oob}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("gnt_out_of_reset", {31'd0, aif.data_gnt}, 32'd1);

      // full write then immediate readback
      issue(1'b1, 32'h40, 4'hF, 32'hA5A5_1234);
      issue(1'b0, 32'h40, 4'hF, 32'h0);
      drain();

      // partial writes and empty byte enable
      issue(1'b1, 32'h44, 4'hF, 32'h1122_3344);
      issue(1'b1, 32'h44, 4'b0010, 32'h0000_FF00);
      issue(1'b0, 32'h44, 4'hF, 32'h0);
      issue(1'b1, 32'h44, 4'b0000, 32'hDEAD_BEEF);
      issue(1'b0, 32'h44, 4'hF, 32'h0);
      drain();

      // just past the end of memory
      issue(1'b1, 32'h0, 4'hF, 32'hCAFE_F00D);
      issue(1'b0, 32'd4 << LOG2, 4'hF, 32'h0);
      issue(1'b1, 32'd4 << LOG2, 4'hF, 32'hFFFF_FFFF);
      issue(1'b0, 32'h0, 4'hF, 32'h0);
      drain();

      // reset while two reads are in flight
      issue(1'b0, 32'h40, 4'hF, 32'h0);
      issue(1'b0, 32'h44, 4'hF, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      aif.data_req = 1'b0;
      sb.delete();
      #1;
      check("midrst_gnt", {31'd0, aif.data_gnt}, 32'd0);
      check("midrst_rvalid", {31'd0, aif.data_rvalid}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("gnt_after_midrst", {31'd0, aif.data_gnt}, 32'd1);
      repeat (4) begin
         @(negedge clk);
         #1;
         check("stale_rvalid", {31'd0, aif.data_rvalid}, 32'd0);
      end

      // random back-to-back traffic over a small initialised window plus out-of-range hits
      for (int w = 0; w < 8; w++) issue(1'b1, (32'h100 + w) << 2, 4'hF, $urandom);
      for (int n = 0; n < 100; n++) begin
         logic [31:0] a;
         if ($urandom_range(0, 9) == 0) begin
            idle();
         end else begin
            if ($urandom_range(0, 11) == 0)
               a = 32'h0001_0000 + ($urandom_range(0, 255) << 2);
            else
               a = ((32'h100 + $urandom_range(0, 7)) << 2) | $urandom_range(0, 3);
            issue(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
         end
      end
      drain();

      // latency 3, two outstanding: grant pattern 1,1,0
      @(negedge clk);
      bif.data_req = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         check("b_gnt", {31'd0, bif.data_gnt}, {31'd0, (i % 3) != 2});
         if (bif.data_gnt) b_acc++;
         @(negedge clk);
      end
      bif.data_req = 1'b0;
      repeat (6) @(negedge clk);
      check("b_accepts", b_acc, 32'd8);
      check("b_rvalids", b_rv, b_acc);

      // two stall cycles: accepts every third cycle
      @(negedge clk);
      cif.data_req = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         check("c_gnt", {31'd0, cif.data_gnt}, {31'd0, (i % 3) == 0});
         if (cif.data_gnt) c_acc++;
         @(negedge clk);
      end
      cif.data_req = 1'b0;
      repeat (6) @(negedge clk);
      check("c_accepts", c_acc, 32'd4);
      c_read(32'h0000_0FFC, 1'b1);
      c_read(32'h0000_1040, 1'b1);
      c_read(32'h0000_103C, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
